// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle sequencer for the 16-bit RISC datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the datapath strobes
// and provides run/stop control, memory wait states, an error halt and a retired counter.
// Optional feature: define SINGLE_STEP_EN to add a 'step' input. A step pulse in IDLE runs
// exactly one instruction and then returns to IDLE.
// dbg_state exposes the FSM state for checkers.
//
// Memory handshake: mem_rd/mem_wr act as the request (valid) and are held every cycle in MEM.
// A transfer completes on the first cycle in which mem_ready (ready) is sampled high with the
// request asserted. The request drops on the following edge.
module multicycle_ctrl_unit #(
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
`ifdef SINGLE_STEP_EN
  input  logic                 step,
`endif
  input  logic [3:0]           opcode,
  input  logic                 mem_ready,
  output logic                 ir_en,
  output logic                 pc_en,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 jump,
  output logic                 beq,
  output logic                 bne,
  output logic                 alu_src,
  output logic                 reg_dest,
  output logic                 mem_to_reg,
  output logic                 reg_wr,
  output logic [1:0]           alu_op,
  output logic                 busy,
  output logic                 illegal,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [2:0]           dbg_state
);

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_LW, C_SW, C_BEQ, C_BNE, C_JMP, C_ILL
  } cls_t;

  state_t               r_state;
  cls_t                 r_cls;
  logic [WW-1:0]        r_wait;
  logic                 r_stop;
  logic                 r_step_mode;
  logic                 r_ir_en, r_pc_en, r_mem_rd, r_mem_wr, r_jump, r_beq, r_bne;
  logic                 r_alu_src, r_reg_dest, r_mem_to_reg, r_reg_wr;
  logic [1:0]           r_alu_op;
  logic                 r_illegal, r_timeout;
  logic [CNT_WIDTH-1:0] r_retired;

  cls_t                 w_cls;
  logic                 w_step;
  logic                 w_busy;
  logic                 w_pc_en;
  logic                 w_stop_eff;
  logic                 w_end_idle;

`ifdef SINGLE_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b0;
`endif

  // Opcode classification used at DECODE.
  always_comb begin
    w_cls = C_ILL;
    case (opcode)
      4'b0000:                                   w_cls = C_LW;
      4'b0001:                                   w_cls = C_SW;
      4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1000, 4'b1001:        w_cls = C_RTYPE;
      4'b1011:                                   w_cls = C_BEQ;
      4'b1100:                                   w_cls = C_BNE;
      4'b1101:                                   w_cls = C_JMP;
      default:                                   w_cls = C_ILL;
    endcase
  end

  assign w_busy     = (r_state != S_IDLE) && (r_state != S_HALT);
  // A store retires in the same cycle its write completes, so its pc_en follows mem_ready directly.
  assign w_pc_en    = r_pc_en | ((r_state == S_MEM) && (r_cls == C_SW) && mem_ready);
  assign w_stop_eff = r_stop | stop;
  assign w_end_idle = w_stop_eff | r_step_mode;

  // Sequencer: state, registered strobes, decoded controls, sticky flags, stop latch, counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cls        <= C_RTYPE;
      r_wait       <= '0;
      r_stop       <= 1'b0;
      r_step_mode  <= 1'b0;
      r_ir_en      <= 1'b0;
      r_pc_en      <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_jump       <= 1'b0;
      r_beq        <= 1'b0;
      r_bne        <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_dest   <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_wr     <= 1'b0;
      r_alu_op     <= 2'b00;
      r_illegal    <= 1'b0;
      r_timeout    <= 1'b0;
      r_retired    <= '0;
    end else begin
      // Single-cycle strobes default low; mem_rd/mem_wr are managed explicitly.
      r_ir_en  <= 1'b0;
      r_pc_en  <= 1'b0;
      r_reg_wr <= 1'b0;
      r_jump   <= 1'b0;
      r_beq    <= 1'b0;
      r_bne    <= 1'b0;

      if (w_pc_en) begin
        r_stop <= 1'b0;
      end else if (w_busy && stop) begin
        r_stop <= 1'b1;
      end

      if (w_pc_en && (r_retired != {CNT_WIDTH{1'b1}})) begin
        r_retired <= r_retired + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_FETCH;
            r_ir_en     <= 1'b1;
            r_step_mode <= 1'b0;
          end else if (w_step) begin
            r_state     <= S_FETCH;
            r_ir_en     <= 1'b1;
            r_step_mode <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_cls <= w_cls;
          if (w_cls == C_ILL) begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end else begin
            r_state      <= S_EXEC;
            r_alu_src    <= (w_cls == C_LW) || (w_cls == C_SW);
            r_reg_dest   <= (w_cls == C_RTYPE);
            r_mem_to_reg <= (w_cls == C_LW);
            r_alu_op     <= (w_cls == C_RTYPE) ? 2'b10 :
                            ((w_cls == C_BEQ) || (w_cls == C_BNE)) ? 2'b01 : 2'b00;
            r_beq        <= (w_cls == C_BEQ);
            r_bne        <= (w_cls == C_BNE);
            r_jump       <= (w_cls == C_JMP);
            r_pc_en      <= (w_cls == C_BEQ) || (w_cls == C_BNE) || (w_cls == C_JMP);
          end
        end
        S_EXEC: begin
          case (r_cls)
            C_RTYPE: begin
              r_state  <= S_WB;
              r_reg_wr <= 1'b1;
              r_pc_en  <= 1'b1;
            end
            C_LW: begin
              r_state  <= S_MEM;
              r_mem_rd <= 1'b1;
              r_wait   <= '0;
            end
            C_SW: begin
              r_state  <= S_MEM;
              r_mem_wr <= 1'b1;
              r_wait   <= '0;
            end
            default: begin
              // Branch/jump retire here.
              r_state      <= w_end_idle ? S_IDLE : S_FETCH;
              r_ir_en      <= !w_end_idle;
              r_alu_src    <= 1'b0;
              r_reg_dest   <= 1'b0;
              r_mem_to_reg <= 1'b0;
              r_alu_op     <= 2'b00;
              if (w_end_idle) r_step_mode <= 1'b0;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (r_cls == C_LW) begin
              r_state  <= S_WB;
              r_reg_wr <= 1'b1;
              r_pc_en  <= 1'b1;
            end else begin
              r_state      <= w_end_idle ? S_IDLE : S_FETCH;
              r_ir_en      <= !w_end_idle;
              r_alu_src    <= 1'b0;
              r_reg_dest   <= 1'b0;
              r_mem_to_reg <= 1'b0;
              r_alu_op     <= 2'b00;
              if (w_end_idle) r_step_mode <= 1'b0;
            end
          end else if (r_wait == WW'(MEM_TIMEOUT - 1)) begin
            r_state      <= S_HALT;
            r_timeout    <= 1'b1;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_dest   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_op     <= 2'b00;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WB: begin
          r_state      <= w_end_idle ? S_IDLE : S_FETCH;
          r_ir_en      <= !w_end_idle;
          r_alu_src    <= 1'b0;
          r_reg_dest   <= 1'b0;
          r_mem_to_reg <= 1'b0;
          r_alu_op     <= 2'b00;
          if (w_end_idle) r_step_mode <= 1'b0;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ir_en      = r_ir_en;
  assign pc_en      = w_pc_en;
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;
  assign jump       = r_jump;
  assign beq        = r_beq;
  assign bne        = r_bne;
  assign alu_src    = r_alu_src;
  assign reg_dest   = r_reg_dest;
  assign mem_to_reg = r_mem_to_reg;
  assign reg_wr     = r_reg_wr;
  assign alu_op     = r_alu_op;
  assign busy       = w_busy;
  assign illegal    = r_illegal;
  assign timeout    = r_timeout;
  assign retired    = r_retired;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: table of per-opcode vectors plus multi-cycle sequences.
module tb_multicycle_ctrl_unit;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          step;
  logic [3:0]    opcode;
  logic          mem_ready;
  logic          ir_en, pc_en, mem_rd, mem_wr, jump, beq, bne;
  logic          alu_src, reg_dest, mem_to_reg, reg_wr;
  logic [1:0]    alu_op;
  logic          busy, illegal, timeout;
  logic [CW-1:0] retired;
  logic [2:0]    dbg_state;

  int total;
  int bad;

  multicycle_ctrl_unit #(.CNT_WIDTH(CW), .MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
`ifdef SINGLE_STEP_EN
    .step       (step),
`endif
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .ir_en      (ir_en),
    .pc_en      (pc_en),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .jump       (jump),
    .beq        (beq),
    .bne        (bne),
    .alu_src    (alu_src),
    .reg_dest   (reg_dest),
    .mem_to_reg (mem_to_reg),
    .reg_wr     (reg_wr),
    .alu_op     (alu_op),
    .busy       (busy),
    .illegal    (illegal),
    .timeout    (timeout),
    .retired    (retired),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controls: {mem_rd, mem_wr, jump, beq, bne, alu_src, reg_dest, mem_to_reg, reg_wr, alu_op}
  logic [10:0] ctrl_v;
  assign ctrl_v = {mem_rd, mem_wr, jump, beq, bne, alu_src, reg_dest, mem_to_reg, reg_wr, alu_op};
  logic [CW+15:0] all_v;
  assign all_v = {ir_en, pc_en, ctrl_v, busy, illegal, timeout, retired, 1'b0, 1'b0};

  typedef struct {
    logic [3:0]  op;
    int          lat;
    logic [10:0] ctrl;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point inside the cycle, after inputs have settled.
  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    mem_ready = 1'b0; opcode = 4'd0;
    #1;
    check("reset_outputs", 32'(all_v), 32'd0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
  endtask

  initial begin
    int lat, n_rd, n_wr, n_pc, n_ir, first_to, m2r_at_pc, jmp_at_pc;
    logic [3:0] ill_ops [3];
    total = 0;
    bad   = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; mem_ready = 1'b0; opcode = 4'd0;

    vecs[0] = '{4'b0010, 4, 11'b00000010110};  // ADD
    vecs[1] = '{4'b0101, 4, 11'b00000010110};  // R-type
    vecs[2] = '{4'b1001, 4, 11'b00000010110};  // last R-type
    vecs[3] = '{4'b0000, 5, 11'b00000101100};  // LW at WB
    vecs[4] = '{4'b0001, 4, 11'b01000100000};  // SW at MEM
    vecs[5] = '{4'b1011, 3, 11'b00010000001};  // BEQ
    vecs[6] = '{4'b1100, 3, 11'b00001000001};  // BNE
    vecs[7] = '{4'b1101, 3, 11'b00100000000};  // JMP

    // Table: one instruction each, stop latched during FETCH, memory always ready.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      opcode = vecs[v].op; mem_ready = 1'b1; start = 1'b1;
      next_cyc();
      start = 1'b0; stop = 1'b1;
      settle();
      check($sformatf("v%0d_ir_en_c1", v), 32'(ir_en), 32'd1);
      check($sformatf("v%0d_busy_c1", v), 32'(busy), 32'd1);
      lat = 0;
      for (int c = 2; c <= 12; c++) begin
        next_cyc();
        stop = 1'b0;
        settle();
        if (pc_en && lat == 0) begin
          lat = c;
          check($sformatf("v%0d_ctrl", v), 32'(ctrl_v), 32'(vecs[v].ctrl));
        end
        if (lat != 0 && c == lat + 1) begin
          check($sformatf("v%0d_busy_after", v), 32'(busy), 32'd0);
          check($sformatf("v%0d_retired", v), 32'(retired), 32'd1);
        end
      end
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
    end

    // LW with two wait cycles: mem_ready high on the third MEM cycle.
    do_reset();
    opcode = 4'b0000; mem_ready = 1'b0; start = 1'b1;
    n_rd = 0; n_pc = 0; lat = 0; m2r_at_pc = 0;
    for (int c = 1; c <= 10; c++) begin
      next_cyc();
      start = 1'b0;
      stop = (c == 1);
      mem_ready = (c == 6);
      settle();
      if (mem_rd) n_rd++;
      if (pc_en) begin
        n_pc++;
        lat = c;
        m2r_at_pc = 32'(mem_to_reg);
      end
    end
    check("lw_wait_mem_rd_cycles", 32'(n_rd), 32'd3);
    check("lw_wait_pc_en_count", 32'(n_pc), 32'd1);
    check("lw_wait_latency", 32'(lat), 32'd7);
    check("lw_wait_mem_to_reg", 32'(m2r_at_pc), 32'd1);
    check("lw_wait_retired", 32'(retired), 32'd1);
    check("lw_wait_busy_end", 32'(busy), 32'd0);

    // SW with mem_ready stuck low: timeout halt after 15 waiting cycles.
    do_reset();
    opcode = 4'b0001; mem_ready = 1'b0; start = 1'b1;
    n_wr = 0; n_pc = 0; first_to = 0;
    for (int c = 1; c <= 25; c++) begin
      next_cyc();
      start = 1'b0;
      settle();
      if (mem_wr) n_wr++;
      if (pc_en) n_pc++;
      if (timeout && first_to == 0) first_to = c;
    end
    check("sw_to_mem_wr_cycles", 32'(n_wr), 32'd15);
    check("sw_to_pc_en_count", 32'(n_pc), 32'd0);
    check("sw_to_first_cycle", 32'(first_to), 32'd19);
    check("sw_to_flags", 32'({timeout, busy, mem_wr, illegal}), 32'b1000);
    check("sw_to_retired", 32'(retired), 32'd0);

    // BEQ with stop arriving in the same cycle as pc_en.
    do_reset();
    opcode = 4'b1011; mem_ready = 1'b1; start = 1'b1;
    next_cyc(); start = 1'b0;
    next_cyc();
    next_cyc(); stop = 1'b1;
    settle();
    check("beq_stop_c3", 32'({beq, pc_en, alu_op}), 32'b1101);
    next_cyc(); stop = 1'b0;
    settle();
    check("beq_stop_c4_idle", 32'({busy, ir_en}), 32'd0);
    next_cyc(); settle();
    check("beq_stop_c5_idle", 32'({busy, ir_en, retired}), 32'd1);

    // Illegal opcodes halt at DECODE; start ignored; reset clears everything.
    ill_ops[0] = 4'b1010; ill_ops[1] = 4'b1110; ill_ops[2] = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      opcode = ill_ops[k]; mem_ready = 1'b0; start = 1'b1;
      next_cyc(); start = 1'b0;
      next_cyc();
      settle();
      check($sformatf("ill%0d_decode", k), 32'({illegal, busy}), 32'b01);
      next_cyc(); settle();
      check($sformatf("ill%0d_halt", k), 32'({illegal, busy, pc_en}), 32'b100);
      n_ir = 0;
      start = 1'b1;
      for (int c = 0; c < 5; c++) begin
        next_cyc(); start = 1'b0; settle();
        if (ir_en || busy) n_ir++;
      end
      check($sformatf("ill%0d_start_ignored", k), 32'(n_ir), 32'd0);
      rst_n = 1'b0;
      #1;
      check($sformatf("ill%0d_reset_clear", k), 32'(all_v), 32'd0);
      rst_n = 1'b1;
    end

    // Reset asserted mid-instruction (EXEC of an ADD) clears outputs at once.
    do_reset();
    opcode = 4'b0010; mem_ready = 1'b1; start = 1'b1;
    next_cyc(); start = 1'b0;
    next_cyc();
    next_cyc();
    settle();
    check("mid_reset_pre_busy", 32'({busy, alu_op, reg_dest}), 32'b1101);
    rst_n = 1'b0;
    #1;
    check("mid_reset_clear", 32'(all_v), 32'd0);
    next_cyc(); settle();
    check("mid_reset_held", 32'(all_v), 32'd0);
    rst_n = 1'b1;

    // Back-to-back jumps: 20 instructions, counter saturates at 2^CW-1.
    do_reset();
    opcode = 4'b1101; mem_ready = 1'b1; start = 1'b1;
    n_pc = 0; n_ir = 0;
    for (int c = 1; c <= 70; c++) begin
      next_cyc();
      start = 1'b0;
      stop = (c == 60);
      settle();
      if (pc_en) n_pc++;
      if (ir_en) n_ir++;
    end
    check("jmp_run_pc_en_count", 32'(n_pc), 32'd20);
    check("jmp_run_ir_en_count", 32'(n_ir), 32'd20);
    check("jmp_run_retired_sat", 32'(retired), 32'd15);
    check("jmp_run_idle", 32'(busy), 32'd0);

`ifdef SINGLE_STEP_EN
    // Single step: one JMP then IDLE.
    do_reset();
    opcode = 4'b1101; mem_ready = 1'b1; step = 1'b1;
    n_pc = 0; n_ir = 0; jmp_at_pc = 0;
    for (int c = 1; c <= 12; c++) begin
      next_cyc();
      step = 1'b0;
      settle();
      if (pc_en) begin
        n_pc++;
        jmp_at_pc = 32'(jump);
      end
      if (ir_en) n_ir++;
    end
    check("step_pc_en_count", 32'(n_pc), 32'd1);
    check("step_ir_en_count", 32'(n_ir), 32'd1);
    check("step_jump", 32'(jmp_at_pc), 32'd1);
    check("step_retired", 32'(retired), 32'd1);
    check("step_idle", 32'(busy), 32'd0);
`else
    jmp_at_pc = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
